// File: rtl/lfo_wave_generator.sv
// Low-frequency oscillator: prescaled phase accumulator feeding a two-register
// waveform pipeline (shape select, then depth scaling around mid-scale).
module lfo_wave_generator #(
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 8,
  parameter int OUT_W      = 10,
  parameter int PRESCALE   = 39063
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               sync,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [1:0]         wave_sel,
  input  logic [7:0]         depth,
  output logic [OUT_W-1:0]   wave_out,
  output logic               out_valid,
  output logic               cycle_start
);
  localparam int L      = LUT_ADDR_W;
  localparam int N      = 1 << L;
  localparam int Q      = N / 4;
  localparam int MID    = 1 << (OUT_W - 1);
  localparam int A      = MID - 1;
  localparam int PW     = OUT_W + L + 2;
  localparam int CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int STAGES = 1;

  localparam logic signed [PW-1:0] A_S  = PW'(A);
  localparam logic signed [PW-1:0] Q2_S = PW'(2 * Q);
  localparam logic signed [PW-1:0] N_S  = PW'(N);
  localparam logic signed [PW-1:0] H_S  = PW'(N / 2);

  // Elaboration-time sine in Q48 fixed point (Taylor series to x^23), rounded to A.
  function automatic logic [OUT_W-1:0] sin_q(input int i);
    logic signed [127:0] x, x2, term, sum, d, r;
    x    = (128'sd884279719003555 * 128'(i)) / 128'(2 * Q);
    x2   = (x * x) >>> 48;
    term = x;
    sum  = x;
    for (int k = 1; k < 22; k += 2) begin
      d    = 128'((k + 1) * (k + 2));
      term = -(((term * x2) >>> 48) / d);
      sum  = sum + term;
    end
    r = (sum * 128'(A) + (128'sd1 <<< 47)) >>> 48;
    return OUT_W'(r);
  endfunction

  function automatic logic signed [PW-1:0] tdiv(input logic signed [PW-1:0] x, input int sh);
    return (x < 0) ? -((-x) >>> sh) : (x >>> sh);
  endfunction

  logic [OUT_W-1:0] sin_rom [0:Q];
  for (genvar g = 0; g <= Q; g++) begin : g_rom
    localparam logic [OUT_W-1:0] V = sin_q(g);
    assign sin_rom[g] = V;
  end

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PHASE_W-1:0]      acc_q, acc_d, acc_sum;
  logic                    carry, wrap_q, wrap_d, tick;
  logic [STAGES:0]         vld_pipe;
  logic signed [OUT_W-1:0] s_q, s_d;
  logic [7:0]              depth_q;
  logic                    wrap_s_q, cs_q;
  logic [OUT_W-1:0]        wave_q, wave_d;

  always_comb begin
    tick           = en && !sync && (cnt_q == CNT_W'(PRESCALE - 1));
    {carry, acc_sum} = {1'b0, acc_q} + {1'b0, phase_inc};
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    wrap_d         = wrap_q;
    if (sync) begin
      cnt_d  = '0;
      acc_d  = '0;
      wrap_d = 1'b1;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_W'(PRESCALE - 1)) ? '0 : cnt_q + 1'b1;
      if (tick) begin
        acc_d  = acc_sum;
        wrap_d = carry;
      end
    end
  end

  // Waveform shaping runs in the tick cycle on the pre-add phase index.
  logic [L-1:0]          p;
  logic [1:0]            quad;
  logic [L-3:0]          idx;
  logic [L-2:0]          ridx;
  logic [OUT_W-1:0]      mag;
  logic signed [PW-1:0]  ps, mag_s, num, s_full;

  assign p = acc_q[PHASE_W-1 -: L];

  always_comb begin
    ps     = $signed(PW'(p));
    quad   = p[L-1:L-2];
    idx    = p[L-3:0];
    ridx   = (L-1)'(Q) - {1'b0, idx};
    mag    = quad[0] ? sin_rom[ridx] : sin_rom[{1'b0, idx}];
    mag_s  = $signed(PW'(mag));
    num    = '0;
    s_full = '0;
    case (wave_sel)
      2'd0: s_full = quad[1] ? -mag_s : mag_s;
      2'd1: begin
        if (p < L'(Q))          num = A_S * ps;
        else if (p < L'(3 * Q)) num = A_S * (Q2_S - ps);
        else                    num = A_S * (ps - N_S);
        s_full = tdiv(num, L - 2);
      end
      2'd2: s_full = p[L-1] ? -A_S : A_S;
      default: begin
        num    = A_S * (ps - H_S);
        s_full = tdiv(num, L - 1);
      end
    endcase
    s_d = OUT_W'(s_full);
  end

  logic signed [OUT_W+8:0] prod;
  assign prod   = (OUT_W+9)'(s_q) * $signed({{OUT_W{1'b0}}, depth_q});
  assign wave_d = OUT_W'(prod >>> 8) + OUT_W'(MID);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      wrap_q   <= 1'b1;
      vld_pipe <= '0;
      s_q      <= '0;
      depth_q  <= '0;
      wrap_s_q <= 1'b0;
      wave_q   <= OUT_W'(MID);
      cs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wrap_q   <= wrap_d;
      vld_pipe <= {vld_pipe[STAGES-1:0], tick};
      if (tick) begin
        s_q      <= s_d;
        depth_q  <= depth;
        wrap_s_q <= wrap_q;
      end
      cs_q <= vld_pipe[0] & wrap_s_q;
      if (vld_pipe[0]) wave_q <= wave_d;
    end
  end

  assign wave_out    = wave_q;
  assign out_valid   = vld_pipe[STAGES];
  assign cycle_start = cs_q;
endmodule
